lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Multi-cycle load/store initiator between the RISC-V CPU datapath and the word-organised data memory. Accepts one byte/half/word load or store per request, issues word-aligned accesses to the memory, performs read-modify-write for sub-word stores, and returns sign/zero-extended load data with a one-cycle done pulse. Memory side matches the data memory port: combinational read, synchronous write.

## Interface
- `ADDR_WIDTH`, 32, byte-address width
- `DATA_WIDTH`, 32, data word width (fixed 32; byte lanes little-endian)
- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `req`  in  1  request strobe; accepted only when `ready`=1
- `we`  in  1  1 = store, 0 = load
- `funct3`  in  3  RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- `addr`  in  ADDR_WIDTH  byte address
- `wdata`  in  DATA_WIDTH  store data, right-justified
- `ready`  out  1  high only in IDLE
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; 1 = illegal/misaligned, no memory access made
- `rd_data`  out  DATA_WIDTH  extended load result, valid when `done` of a load, held until next load completes
- `mem_addr`  out  ADDR_WIDTH  word-aligned address `{addr[31:2],2'b00}` of captured request
- `mem_wr_en`  out  1  memory write enable
- `mem_wr_data`  out  DATA_WIDTH  full merged word to write
- `mem_rd_data`  in  DATA_WIDTH  combinational memory read word

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: `ready`=1. On `req`: capture we/funct3/addr/wdata. Illegal funct3 (011, 110, 111; or 1xx with `we`=1) or misaligned (see Configuration) -> RESP with err=1. Load -> RD. Word store -> WR. Byte/half store -> RD.
- RD: `mem_addr` driven; register `mem_rd_data` into internal word buffer at edge. Load -> RESP (extraction done at the edge into `rd_data`). Sub-word store -> WR.
- WR: `mem_wr_en`=1, `mem_wr_data` = buffer with selected lane(s) replaced by `wdata[7:0]`/`wdata[15:0]` at byte offset `addr[1:0]`; word store writes `wdata` directly. -> RESP.
- RESP: `done`=1 for one cycle, `err` per request. -> IDLE.
- Load extraction: byte lane `addr[1:0]`, half lane `addr[1]`; B/H sign-extend from bit 7/15, BU/HU zero-extend.
- `mem_wr_en` = (state==WR) && `rst_n`; never high in any other state.
- `req` while not `ready` is ignored (no queueing).

## Timing
- Request accepted at edge 0 (IDLE, req=1).
- Load: RD cycle 1, `done` cycle 2. Latency 2, throughput one per 3 cycles.
- Word store: WR cycle 1 (write at end of cycle 1), `done` cycle 2.
- Sub-word store: RD cycle 1, WR cycle 2, `done` cycle 3.
- Error: `done`+`err` cycle 1, no RD/WR.
- Reset values: state IDLE, `ready`=1, `done`=0, `err`=0, `rd_data`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, buffer 0.
- Reset mid-operation: `rst_n`=0 in WR cycle suppresses the write; any partial RMW is abandoned, no `done` issued.
- Back-to-back: `req` high during RESP is ignored; next acceptance earliest the cycle after RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: half with `addr[0]`=1 or word with `addr[1:0]`!=0 -> err response, no memory access.
- Undefined: misalignment never errors; offending low bits forced to zero (half uses `addr[1]` only, word uses lane 0); `err` only for illegal funct3.

## Test plan
- Reset: drive `rst_n`=0 two cycles -> `ready`=1, `done`=0, `mem_wr_en`=0, `rd_data`=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> write in cycle 1, `done` cycle 2; load `rd_data`=0xDEADBEEF on its `done`.
- SB 0x13 data 0x000000AA over 0x11223344 -> RD then WR, memory word 0xAA223344; LB 0x13 -> 0xFFFFFFAA, LBU 0x13 -> 0x000000AA.
- SH 0x16 data 0x8001 over 0x00000000 -> word 0x80010000; LH 0x16 -> 0xFFFF8001, LHU 0x16 -> 0x00008001.
- LW 0x21 -> with macro: `done`+`err`=1 cycle 1, no `mem_wr_en`; without: returns word at 0x20, `err`=0. funct3=011 -> `err`=1 both builds.
- SB in progress, `rst_n`=0 during WR cycle -> `mem_wr_en`=0, memory word unchanged, no `done`, IDLE after reset.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: word-aligned memory accesses, read-modify-write for sub-word stores,
// sign/zero-extended loads. Define LSU_MISALIGN_TRAP_EN to turn misaligned H/W accesses into errors.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  err_q, err_d;

  logic                  illegal;
  logic                  misalign;
  logic [1:0]            lane;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [3:0]            mask;
  logic [DATA_WIDTH-1:0] rep;
  logic [DATA_WIDTH-1:0] merged;

  assign illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                   (funct3[2] && we);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Without trapping, misaligned low bits are simply dropped: halves use addr[1], words lane 0.
  always_comb begin
    lane = 2'b00;
    if (f3_q[1:0] == 2'b00)      lane = addr_q[1:0];
    else if (f3_q[1:0] == 2'b01) lane = {addr_q[1], 1'b0};
  end

  always_comb begin
    shifted  = mem_rd_data >> {lane, 3'b000};
    load_ext = shifted;
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'b0, shifted[7:0]};
      3'b101:  load_ext = {16'b0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    mask = 4'hF;
    rep  = wdata_q;
    if (f3_q[1:0] == 2'b00) begin
      mask = 4'b0001 << lane;
      rep  = {4{wdata_q[7:0]}};
    end else if (f3_q[1:0] == 2'b01) begin
      mask = 4'b0011 << lane;
      rep  = {2{wdata_q[15:0]}};
    end
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = mask[i] ? rep[8*i +: 8] : buf_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          f3_d    = funct3;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = illegal || misalign;
          if (illegal || misalign)        state_d = RESP;
          else if (we && funct3 == 3'b010) state_d = WR;
          else                             state_d = RD;
        end
      end
      RD: begin
        buf_d = mem_rd_data;
        if (we_q) begin
          state_d = WR;
        end else begin
          rd_data_d = load_ext;
          state_d   = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= 3'b000;
      addr_q    <= '0;
      wdata_q   <= '0;
      buf_q     <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      buf_q     <= buf_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign done        = (state_q == RESP);
  assign err         = (state_q == RESP) && err_q;
  assign rd_data     = rd_data_q;
  assign mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  // Gating with rst_n lets a reset asserted during WR kill the write at that same edge.
  assign mem_wr_en   = (state_q == WR) && rst_n;
  assign mem_wr_data = merged;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small word memory (combinational read, synchronous write).
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, done, err, mem_wr_en;
  logic [31:0] rd_data, mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [0:63];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;

  int n_assert = 0;
  int n_fail   = 0;

  int          lat, wrc, busy_rdy;
  logic        e;
  logic [31:0] rd;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .err(err), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  assign mem_rd_data = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_wr_en)  mem[mem_addr[7:2]] <= mem_wr_data;
    else if (pl_en) mem[pl_idx] <= pl_dat;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_dat = dat;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Returns done cycle (-1 on timeout), first cycle with mem_wr_en (-1 if none), err/rd_data at done.
  task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                       output int lat_o, output int wrc_o, output logic e_o, output logic [31:0] rd_o,
                       output int busy_rdy_o);
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0;
    lat_o = -1; wrc_o = -1; e_o = 1'bx; rd_o = 'x; busy_rdy_o = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (mem_wr_en && wrc_o < 0) wrc_o = cyc;
      if (done) begin
        lat_o = cyc; e_o = err; rd_o = rd_data;
        break;
      end
      if (ready) busy_rdy_o++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_wr_data", mem_wr_data, 32'h0);
    rst_n = 1'b1;

    // Word store then word load
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, lat, wrc, e, rd, busy_rdy);
    check("sw_lat", lat, 2);
    check("sw_wr_cycle", wrc, 1);
    check("sw_err", {31'b0, e}, 32'd0);
    check("sw_busy_ready", busy_rdy, 0);
    @(negedge clk);
    check("sw_done_pulse", {31'b0, done}, 32'd0);
    check("sw_ready_after", {31'b0, ready}, 32'd1);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h10, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lw_lat", lat, 2);
    check("lw_no_write", wrc, -1);
    check("lw_data", rd, 32'hDEADBEEF);

    // Byte store read-modify-write, byte loads
    preload(6'd4, 32'h11223344);
    issue(1'b1, 3'b000, 32'h13, 32'h000000AA, lat, wrc, e, rd, busy_rdy);
    check("sb_lat", lat, 3);
    check("sb_wr_cycle", wrc, 2);
    check("sb_rd_data_held", rd, 32'hDEADBEEF);
    @(negedge clk);
    check("sb_mem", mem[4], 32'hAA223344);
    issue(1'b0, 3'b000, 32'h13, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lb_lat", lat, 2);
    check("lb_data", rd, 32'hFFFFFFAA);
    issue(1'b0, 3'b100, 32'h13, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lbu_data", rd, 32'h000000AA);
    issue(1'b0, 3'b000, 32'h10, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lb_lane0", rd, 32'h00000044);

    // Half store, half loads
    preload(6'd5, 32'h00000000);
    issue(1'b1, 3'b001, 32'h16, 32'h00008001, lat, wrc, e, rd, busy_rdy);
    check("sh_lat", lat, 3);
    @(negedge clk);
    check("sh_mem", mem[5], 32'h80010000);
    issue(1'b0, 3'b001, 32'h16, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lh_data", rd, 32'hFFFF8001);
    issue(1'b0, 3'b101, 32'h16, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lhu_data", rd, 32'h00008001);

    // Misaligned accesses
    preload(6'd8, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h21, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_err", {31'b0, e}, 32'd1);
    check("lw_mis_no_write", wrc, -1);
    check("lw_mis_rd_held", rd, 32'h00008001);
    issue(1'b0, 3'b001, 32'h17, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lh_mis_err", {31'b0, e}, 32'd1);
    issue(1'b1, 3'b010, 32'h22, 32'h12345678, lat, wrc, e, rd, busy_rdy);
    check("sw_mis_no_write", wrc, -1);
    check("sw_mis_mem", mem[8], 32'hCAFEF00D);
`else
    issue(1'b0, 3'b010, 32'h21, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lw_mis_lat", lat, 2);
    check("lw_mis_err", {31'b0, e}, 32'd0);
    check("lw_mis_data", rd, 32'hCAFEF00D);
    issue(1'b0, 3'b001, 32'h17, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("lh_mis_err", {31'b0, e}, 32'd0);
    check("lh_mis_data", rd, 32'hFFFF8001);
    issue(1'b1, 3'b010, 32'h22, 32'h12345678, lat, wrc, e, rd, busy_rdy);
    check("sw_mis_wr_cycle", wrc, 1);
    @(negedge clk);
    check("sw_mis_mem", mem[8], 32'h12345678);
`endif

    // Illegal funct3
    issue(1'b0, 3'b011, 32'h10, 32'h0, lat, wrc, e, rd, busy_rdy);
    check("f011_lat", lat, 1);
    check("f011_err", {31'b0, e}, 32'd1);
    issue(1'b1, 3'b100, 32'h10, 32'h55, lat, wrc, e, rd, busy_rdy);
    check("sbu_err", {31'b0, e}, 32'd1);
    check("sbu_no_write", wrc, -1);
    check("sbu_mem", mem[4], 32'hAA223344);

    // Reset during the WR cycle of a byte store
    preload(6'd4, 32'h12345678);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h10; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    check("rmw_rd_busy", {31'b0, ready}, 32'd0);
    @(negedge clk);
    check("rmw_wr_state", {31'b0, mem_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rmw_rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
    @(negedge clk);
    check("rmw_rst_done", {31'b0, done}, 32'd0);
    check("rmw_rst_ready", {31'b0, ready}, 32'd1);
    check("rmw_rst_rd_data", rd_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rmw_after_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    check("rmw_mem_kept", mem[4], 32'h12345678);
    check("rmw_idle", {31'b0, ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
